j_result_deser: RTL and testbench

J_RESULT_DESER -- requirements
Module: j_result_deser

---
 rtl/j_pkg.sv | 12 +
 rtl/j_sync_fifo.sv | 53 +++++
 rtl/j_result_deser.sv | 104 ++++++++++
 tb/tb_j_result_deser.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/j_pkg.sv
// Shared types and defaults for the J-array result path.
package j_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned OUT_W_DEF      = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/j_sync_fifo.sv
// Single-clock FIFO with registered storage; pop of an empty FIFO is ignored and
// a push into a full FIFO only lands when a pop frees a slot in the same cycle.
module j_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/j_result_deser.sv
// Collects the LSB-first bit-serial MAC result into OUT_W-bit words and queues
// them for the consumer; frame_start inside a word aborts it and flags frame_err.
module j_result_deser
  import j_pkg::*;
#(
  parameter int unsigned OUT_W      = OUT_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_valid,
  input  logic             serial_in,
  input  logic             frame_start,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             drop_pulse,
  output logic             frame_err,
  input  logic             clear_err,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(OUT_W);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [OUT_W-1:0] word_q;
  logic             frame_err_q;
  logic             drop_q;
  logic             busy_q;

  logic             push_c;
  logic [OUT_W-1:0] push_data_c;
  logic             abort_c;
  logic             pop_c;
  logic             fifo_full;
  logic             fifo_empty;

  // The final bit goes straight into the FIFO alongside the bits already held.
  always_comb begin
    push_c      = 1'b0;
    push_data_c = {serial_in, word_q[OUT_W-2:0]};
    abort_c     = 1'b0;
    if (state_q == SHIFT && bit_valid) begin
      if (frame_start) abort_c = 1'b1;
      else if (cnt_q == CNT_W'(OUT_W - 1)) push_c = 1'b1;
    end
  end

  assign pop_c = out_ready & ~fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      frame_err_q <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      drop_q <= push_c & fifo_full & ~pop_c;
      if (abort_c)        frame_err_q <= 1'b1;
      else if (clear_err) frame_err_q <= 1'b0;

      if (bit_valid) begin
        if (frame_start) begin
          word_q  <= OUT_W'(serial_in);
          cnt_q   <= CNT_W'(1);
          state_q <= SHIFT;
          busy_q  <= 1'b1;
        end else if (state_q == SHIFT) begin
          if (push_c) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            word_q[cnt_q] <= serial_in;
            cnt_q         <= cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  j_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push_c),
    .push_data (push_data_c),
    .pop       (pop_c),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid  = ~fifo_empty;
  assign drop_pulse = drop_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_j_result_deser.sv
// Directed bench for j_result_deser with a queue-based reference model.
module tb_j_result_deser;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         bit_valid = 1'b0;
  logic         serial_in = 1'b0;
  logic         frame_start = 1'b0;
  logic         out_ready = 1'b0;
  logic         clear_err = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         drop_pulse;
  logic         frame_err;
  logic         busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  j_result_deser #(.OUT_W(W), .FIFO_DEPTH(D)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bit_valid   (bit_valid),
    .serial_in   (serial_in),
    .frame_start (frame_start),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .drop_pulse  (drop_pulse),
    .frame_err   (frame_err),
    .clear_err   (clear_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bit list per frame and a bounded word queue.
  logic [W-1:0] mq[$];
  bit           bitq[$];
  bit           m_coll = 1'b0;
  bit           m_err = 1'b0;
  bit           m_drop = 1'b0;
  bit           m_pop_ok;
  bit           m_have;
  bit           m_abort;
  logic [W-1:0] m_w;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      bitq.delete();
      m_coll = 1'b0;
      m_err  = 1'b0;
      m_drop = 1'b0;
    end else begin
      m_drop   = 1'b0;
      m_have   = 1'b0;
      m_pop_ok = (mq.size() > 0) && out_ready;
      m_abort  = bit_valid && frame_start && m_coll;
      if (bit_valid) begin
        if (frame_start) begin
          bitq.delete();
          bitq.push_back(serial_in);
          m_coll = 1'b1;
        end else if (m_coll) begin
          bitq.push_back(serial_in);
        end
      end
      if (m_abort) m_err = 1'b1;
      else if (clear_err) m_err = 1'b0;
      if (m_coll && bitq.size() == W) begin
        m_w = '0;
        foreach (bitq[i]) m_w[i] = bitq[i];
        m_have = 1'b1;
        m_coll = 1'b0;
        bitq.delete();
      end
      if (m_pop_ok) void'(mq.pop_front());
      if (m_have) begin
        if (mq.size() < D) mq.push_back(m_w);
        else m_drop = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    chk("busy", 32'(busy), 32'(m_coll));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
  end

  task automatic cyc(input bit bv, input bit si, input bit fs, input bit rdy, input bit clr);
    bit_valid   = bv;
    serial_in   = si;
    frame_start = fs;
    out_ready   = rdy;
    clear_err   = clr;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input bit rdy, input bit last_rdy);
    for (int i = 0; i < int'(W); i++) begin
      cyc(1'b1, w[i], i == 0, (i == int'(W) - 1) ? last_rdy : rdy, 1'b0);
      for (int g = 0; g < gap && i < int'(W) - 1; g++) cyc(1'b0, 1'b1, 1'b0, rdy, 1'b0);
    end
  endtask

  logic [W-1:0] rw;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // Back-to-back word, visible the cycle after its last bit.
    send_word(16'hA5C3, 0, 1, 1);
    chk("t1_valid", 32'(out_valid), 32'h1);
    chk("t1_data", 32'(out_data), 32'hA5C3);
    cyc(0, 0, 0, 1, 0);
    chk("t1_popped", 32'(out_valid), 32'h0);

    // Gapped bit_valid; noise on serial_in during gaps.
    send_word(16'h8001, 2, 1, 1);
    chk("t2_data", 32'(out_data), 32'h8001);
    cyc(0, 0, 0, 1, 0);

    // Overflow: fifth word dropped.
    for (int k = 1; k <= 4; k++) send_word(W'(k), 0, 0, 0);
    chk("t3_nodrop4", 32'(drop_pulse), 32'h0);
    send_word(16'h0005, 0, 0, 0);
    chk("t3_drop5", 32'(drop_pulse), 32'h1);
    cyc(0, 0, 0, 0, 0);
    chk("t3_drop_once", 32'(drop_pulse), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      chk("t3_drain", 32'(out_data), 32'(k));
      cyc(0, 0, 0, 1, 0);
    end
    chk("t3_empty", 32'(out_valid), 32'h0);

    // Full FIFO with simultaneous pop and push.
    send_word(16'h0011, 0, 0, 0);
    send_word(16'h0022, 0, 0, 0);
    send_word(16'h0033, 0, 0, 0);
    send_word(16'h0044, 0, 0, 0);
    send_word(16'h0055, 0, 0, 1);
    chk("t4_nodrop", 32'(drop_pulse), 32'h0);
    chk("t4_head", 32'(out_data), 32'h0022);
    cyc(0, 0, 0, 0, 0);
    send_word(16'h0066, 0, 0, 0);
    chk("t4_still_full", 32'(drop_pulse), 32'h1);
    cyc(0, 0, 0, 0, 0);
    for (int k = 2; k <= 5; k++) begin
      chk("t4_drain", 32'(out_data), 32'(k * 16'h11));
      cyc(0, 0, 0, 1, 0);
    end
    chk("t4_empty", 32'(out_valid), 32'h0);

    // Abort after 7 bits, then a full word; then clear.
    for (int i = 0; i < 7; i++) cyc(1, i[0], i == 0, 1, 0);
    send_word(16'h1234, 0, 1, 1);
    chk("t5_err", 32'(frame_err), 32'h1);
    chk("t5_data", 32'(out_data), 32'h1234);
    cyc(0, 0, 0, 1, 0);
    chk("t5_no_partial", 32'(out_valid), 32'h0);
    cyc(0, 0, 0, 1, 1);
    chk("t5_cleared", 32'(frame_err), 32'h0);
    cyc(1, 0, 1, 1, 0);
    cyc(1, 1, 1, 1, 1);
    chk("t5_set_wins", 32'(frame_err), 32'h1);

    // Reset in the middle of a word with two words queued.
    send_word(16'hAAAA, 0, 0, 0);
    send_word(16'h5555, 0, 0, 0);
    rw = 16'h0F0F;
    for (int i = 0; i < 9; i++) cyc(1, rw[i], i == 0, 0, 0);
    chk("t6_queued", 32'(out_data), 32'hAAAA);
    bit_valid = 1'b1;
    serial_in = rw[9];
    frame_start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'h0);
    chk("t6_rst_data", 32'(out_data), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    chk("t6_rst_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    bit_valid = 1'b0;
    reset_n = 1'b1;
    cyc(0, 0, 0, 1, 0);
    send_word(16'hFFFF, 0, 1, 1);
    chk("t6_data", 32'(out_data), 32'hFFFF);
    chk("t6_valid", 32'(out_valid), 32'h1);
    cyc(0, 0, 0, 1, 0);
    chk("t6_empty", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
